// File: rtl/clint_apb_arbiter.sv
// clint_apb_arbiter: round-robin sharing of the CLINT APB slave port between NREQ requesters,
// with a watchdog that aborts transfers the slave never completes.
package config_pkg;
    localparam int XLEN = 32;
endpackage

module clint_apb_arbiter
    import config_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic [NREQ-1:0]          ReqValid,
    input  logic [NREQ-1:0]          ReqWrite,
    input  logic [NREQ*16-1:0]       ReqAddr,
    input  logic [NREQ*XLEN-1:0]     ReqWData,
    input  logic [NREQ*XLEN/8-1:0]   ReqStrb,
    output logic [NREQ-1:0]          ReqReady,
    output logic [NREQ-1:0]          RspValid,
    output logic [XLEN-1:0]          RspData,
    output logic                     RspErr,
    output logic                     Busy,
    output logic                     PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [15:0]              PADDR,
    output logic [XLEN-1:0]          PWDATA,
    output logic [XLEN/8-1:0]        PSTRB,
    input  logic [XLEN-1:0]          PRDATA,
    input  logic                     PREADY
);
    localparam int IW = $clog2(NREQ);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int SW = XLEN / 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     last_q, last_d, gnt_q, gnt_d, gsel;
    logic              wr_q, wr_d;
    logic [15:0]       addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d, rsp_data_q, rsp_data_d;
    logic [SW-1:0]     strb_q, strb_d;
    logic [WW-1:0]     wd_q, wd_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              done, grant;
    int                idx;

    always_comb begin
        gsel = '0;
        idx  = 0;
        // Scan downward so the last match written is the first one after last_q.
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last_q) + k) % NREQ;
            if (ReqValid[idx]) gsel = IW'(idx);
        end
        done  = (state_q == ACCESS) && (PREADY || wd_q == WW'(TIMEOUT - 1));
        grant = (state_q == IDLE || done) && |ReqValid;
        ReqReady = grant ? NREQ'(1) << gsel : '0;
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        wd_d        = wd_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE:    state_d = grant ? SETUP : IDLE;
            SETUP: begin
                state_d = ACCESS;
                wd_d    = '0;
            end
            default: begin
                state_d = done ? (grant ? SETUP : IDLE) : ACCESS;
                wd_d    = PREADY ? wd_q : wd_q + 1'b1;
            end
        endcase
        if (done) begin
            rsp_valid_d = NREQ'(1) << gnt_q;
            rsp_data_d  = PREADY ? PRDATA : '0;
            rsp_err_d   = !PREADY;
        end
        if (grant) begin
            last_d  = gsel;
            gnt_d   = gsel;
            wr_d    = ReqWrite[gsel];
            addr_d  = ReqAddr[gsel*16 +: 16];
            wdata_d = ReqWData[gsel*XLEN +: XLEN];
            strb_d  = ReqStrb[gsel*SW +: SW];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            last_q      <= IW'(NREQ - 1);
            gnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            wd_q        <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            wd_q        <= wd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign Busy     = state_q != IDLE;
    assign PSEL     = state_q != IDLE;
    assign PENABLE  = state_q == ACCESS;
    assign PWRITE   = wr_q;
    assign PADDR    = addr_q;
    assign PWDATA   = wdata_q;
    assign PSTRB    = wr_q ? strb_q : '0;
    assign RspValid = rsp_valid_q;
    assign RspData  = rsp_data_q;
    assign RspErr   = rsp_err_q;
endmodule

// File: tb/tb_clint_apb_arbiter.sv
// tb_clint_apb_arbiter: directed checks of arbitration, APB sequencing, watchdog and reset
// on a 2-requester instance (u2) and a 4-requester instance (u4).
module tb_clint_apb_arbiter;
    logic        PCLK, PRESETn, PREADY;
    logic [31:0] PRDATA;
    int          errs, checks;

    logic [1:0]  v2, w2, rdy2, rv2;
    logic [31:0] a2, rd2, pd2;
    logic [63:0] d2;
    logic [7:0]  s2;
    logic        re2, bz2, sel2, en2, pw2;
    logic [15:0] pa2;
    logic [3:0]  ps2;

    logic [3:0]   v4, w4, rdy4, rv4;
    logic [63:0]  a4;
    logic [127:0] d4;
    logic [15:0]  s4, pa4;
    logic [31:0]  rd4, pd4;
    logic         re4, bz4, sel4, en4, pw4;
    logic [3:0]   ps4;

    clint_apb_arbiter #(.NREQ(2), .TIMEOUT(16)) u2 (
        .PCLK(PCLK), .PRESETn(PRESETn), .ReqValid(v2), .ReqWrite(w2), .ReqAddr(a2),
        .ReqWData(d2), .ReqStrb(s2), .ReqReady(rdy2), .RspValid(rv2), .RspData(rd2),
        .RspErr(re2), .Busy(bz2), .PSEL(sel2), .PENABLE(en2), .PWRITE(pw2), .PADDR(pa2),
        .PWDATA(pd2), .PSTRB(ps2), .PRDATA(PRDATA), .PREADY(PREADY));

    clint_apb_arbiter #(.NREQ(4), .TIMEOUT(16)) u4 (
        .PCLK(PCLK), .PRESETn(PRESETn), .ReqValid(v4), .ReqWrite(w4), .ReqAddr(a4),
        .ReqWData(d4), .ReqStrb(s4), .ReqReady(rdy4), .RspValid(rv4), .RspData(rd4),
        .RspErr(re4), .Busy(bz4), .PSEL(sel4), .PENABLE(en4), .PWRITE(pw4), .PADDR(pa4),
        .PWDATA(pd4), .PSTRB(ps4), .PRDATA(PRDATA), .PREADY(PREADY));

    initial PCLK = 0;
    always #5 PCLK = ~PCLK;

    task automatic tick;
        @(posedge PCLK);
        #2;
    endtask

    task automatic test_reset;
        PRESETn = 0; PREADY = 0; PRDATA = 0;
        v2 = 0; w2 = 0; a2 = 0; d2 = 0; s2 = 0;
        v4 = 0; w4 = 0; a4 = 0; d4 = 0; s4 = 0;
        #3;
        checks++; if ({sel2, en2, bz2, re2} !== 4'b0) begin errs++; $display("FAIL rst_ctl got=%b exp=0000", {sel2, en2, bz2, re2}); end
        checks++; if ({rdy2, rv2} !== 4'b0) begin errs++; $display("FAIL rst_hs got=%b exp=0000", {rdy2, rv2}); end
        checks++; if ({rd2, pa2, ps2} !== 52'b0) begin errs++; $display("FAIL rst_data got=%h exp=0", {rd2, pa2, ps2}); end
        checks++; if ({rdy4, rv4, sel4} !== 9'b0) begin errs++; $display("FAIL rst_u4 got=%b exp=0", {rdy4, rv4, sel4}); end
        tick;
        PRESETn = 1;
        tick;
    endtask

    task automatic test_write;
        v2 = 2'b01; w2 = 2'b01; a2 = {16'h0, 16'h4000}; d2 = {32'h0, 32'h5}; s2 = 8'hFF;
        #1;
        checks++; if (rdy2 !== 2'b01) begin errs++; $display("FAIL wr_grant got=%b exp=01", rdy2); end
        tick;
        v2 = 0;
        #1;
        checks++; if ({sel2, en2, pw2, bz2} !== 4'b1011) begin errs++; $display("FAIL wr_setup got=%b exp=1011", {sel2, en2, pw2, bz2}); end
        checks++; if ({pa2, pd2, ps2} !== {16'h4000, 32'h5, 4'hF}) begin errs++; $display("FAIL wr_apb got=%h exp=%h", {pa2, pd2, ps2}, {16'h4000, 32'h5, 4'hF}); end
        checks++; if (rdy2 !== 2'b00) begin errs++; $display("FAIL wr_noready_setup got=%b exp=00", rdy2); end
        tick;
        PREADY = 1;
        #1;
        checks++; if ({sel2, en2, ps2} !== 6'b11_1111) begin errs++; $display("FAIL wr_access got=%b exp=111111", {sel2, en2, ps2}); end
        tick;
        PREADY = 0;
        #1;
        checks++; if ({rv2, re2} !== 3'b010) begin errs++; $display("FAIL wr_rsp got=%b exp=010", {rv2, re2}); end
        checks++; if ({sel2, bz2} !== 2'b00) begin errs++; $display("FAIL wr_idle got=%b exp=00", {sel2, bz2}); end
        tick;
        checks++; if (rv2 !== 2'b00) begin errs++; $display("FAIL wr_pulse got=%b exp=00", rv2); end
    endtask

    task automatic test_read;
        v2 = 2'b01; w2 = 2'b00; a2 = {16'h0, 16'hBFF8}; s2 = 8'hFF;
        #1;
        checks++; if (rdy2 !== 2'b01) begin errs++; $display("FAIL rd_grant got=%b exp=01", rdy2); end
        tick;
        v2 = 0;
        #1;
        checks++; if ({pw2, ps2, pa2} !== {1'b0, 4'h0, 16'hBFF8}) begin errs++; $display("FAIL rd_setup got=%h exp=0bff8", {pw2, ps2, pa2}); end
        tick;
        PREADY = 1; PRDATA = 32'h1234;
        #1;
        checks++; if ({en2, ps2} !== 5'b1_0000) begin errs++; $display("FAIL rd_access got=%b exp=10000", {en2, ps2}); end
        tick;
        PREADY = 0; PRDATA = 32'h0;
        #1;
        checks++; if ({rv2, re2, rd2} !== {2'b01, 1'b0, 32'h1234}) begin errs++; $display("FAIL rd_rsp got=%h exp=%h", {rv2, re2, rd2}, {2'b01, 1'b0, 32'h1234}); end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [1:0] e;
        PRESETn = 0; #1; PRESETn = 1;
        tick;
        a2 = {16'h0020, 16'h0010}; w2 = 0; s2 = 8'hFF; PREADY = 1; PRDATA = 32'h77; v2 = 2'b11;
        for (int k = 0; k < 4; k++) begin
            e = 2'b01 << (k % 2);
            #1;
            checks++; if (rdy2 !== e) begin errs++; $display("FAIL b2b_grant%0d got=%b exp=%b", k, rdy2, e); end
            if (k > 0) begin
                checks++; if (en2 !== 1'b1) begin errs++; $display("FAIL b2b_access%0d got=%b exp=1", k, en2); end
            end
            tick;
            #1;
            checks++; if ({sel2, en2, pa2} !== {2'b10, (k % 2 == 1) ? 16'h0020 : 16'h0010}) begin errs++; $display("FAIL b2b_setup%0d got=%h", k, {sel2, en2, pa2}); end
            checks++; if (rv2 !== ((k == 0) ? 2'b00 : (e ^ 2'b11))) begin errs++; $display("FAIL b2b_rsp%0d got=%b exp=%b", k, rv2, (k == 0) ? 2'b00 : (e ^ 2'b11)); end
            if (k == 3) v2 = 0;
            tick;
        end
        #1;
        checks++; if (rdy2 !== 2'b00) begin errs++; $display("FAIL b2b_last got=%b exp=00", rdy2); end
        tick;
        PREADY = 0;
        #1;
        checks++; if ({rv2, sel2} !== 3'b100) begin errs++; $display("FAIL b2b_end got=%b exp=100", {rv2, sel2}); end
        tick;
    endtask

    task automatic test_timeout;
        int n;
        PRDATA = 32'hDEADBEEF; PREADY = 0;
        v2 = 2'b01; w2 = 2'b01; a2 = {16'h0, 16'h4008}; s2 = 8'h0F;
        #1;
        checks++; if (rdy2 !== 2'b01) begin errs++; $display("FAIL to_grant got=%b exp=01", rdy2); end
        tick;
        v2 = 0;
        tick;
        n = 0;
        while (en2 === 1'b1 && n < 40) begin
            n++;
            tick;
        end
        checks++; if (n !== 16) begin errs++; $display("FAIL to_cycles got=%0d exp=16", n); end
        checks++; if ({rv2, re2, rd2} !== {2'b01, 1'b1, 32'h0}) begin errs++; $display("FAIL to_rsp got=%h exp=%h", {rv2, re2, rd2}, {2'b01, 1'b1, 32'h0}); end
        v2 = 2'b10; w2 = 2'b00; a2 = {16'h000C, 16'h0};
        #1;
        checks++; if (rdy2 !== 2'b10) begin errs++; $display("FAIL to_next_grant got=%b exp=10", rdy2); end
        tick;
        v2 = 0;
        tick;
        PREADY = 1; PRDATA = 32'hCAFE;
        tick;
        PREADY = 0;
        #1;
        checks++; if ({rv2, re2, rd2} !== {2'b10, 1'b0, 32'hCAFE}) begin errs++; $display("FAIL to_next_rsp got=%h exp=%h", {rv2, re2, rd2}, {2'b10, 1'b0, 32'hCAFE}); end
        tick;
    endtask

    task automatic test_reset_mid;
        v2 = 2'b01; w2 = 2'b01; a2 = {16'h0, 16'h4000};
        tick;
        v2 = 0;
        tick;
        #1;
        checks++; if (en2 !== 1'b1) begin errs++; $display("FAIL rm_access got=%b exp=1", en2); end
        PRESETn = 0;
        #1;
        checks++; if ({sel2, en2, bz2, rv2} !== 5'b0) begin errs++; $display("FAIL rm_drop got=%b exp=00000", {sel2, en2, bz2, rv2}); end
        tick;
        checks++; if ({sel2, rv2} !== 3'b0) begin errs++; $display("FAIL rm_hold got=%b exp=000", {sel2, rv2}); end
        PRESETn = 1;
        v2 = 2'b10; w2 = 2'b00;
        #1;
        checks++; if (rdy2 !== 2'b10) begin errs++; $display("FAIL rm_grant1 got=%b exp=10", rdy2); end
        tick;
        v2 = 0;
        tick;
        PREADY = 1;
        tick;
        PREADY = 0;
        #1;
        checks++; if (rv2 !== 2'b10) begin errs++; $display("FAIL rm_rsp got=%b exp=10", rv2); end
        tick;
    endtask

    task automatic test_wrap;
        PRESETn = 0; #1; PRESETn = 1;
        tick;
        a4 = {16'h0333, 16'h0222, 16'h0111, 16'h0000}; w4 = 0; v4 = 4'b1010;
        #1;
        checks++; if (rdy4 !== 4'b0010) begin errs++; $display("FAIL wrap_g1 got=%b exp=0010", rdy4); end
        tick;
        v4 = 4'b1000;
        #1;
        checks++; if (pa4 !== 16'h0111) begin errs++; $display("FAIL wrap_addr1 got=%h exp=0111", pa4); end
        tick;
        PREADY = 1;
        #1;
        checks++; if (rdy4 !== 4'b1000) begin errs++; $display("FAIL wrap_g3 got=%b exp=1000", rdy4); end
        tick;
        v4 = 0; PREADY = 0;
        #1;
        checks++; if ({rv4, pa4} !== {4'b0010, 16'h0333}) begin errs++; $display("FAIL wrap_setup3 got=%h exp=%h", {rv4, pa4}, {4'b0010, 16'h0333}); end
        tick;
        PREADY = 1;
        tick;
        PREADY = 0;
        #1;
        checks++; if (rv4 !== 4'b1000) begin errs++; $display("FAIL wrap_rsp3 got=%b exp=1000", rv4); end
        tick;
    endtask

    initial begin
        errs = 0; checks = 0;
        test_reset;
        test_write;
        test_read;
        test_back_to_back;
        test_timeout;
        test_reset_mid;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached time=%0t limit=200000", $time);
        $fatal(1, "bench did not terminate");
    end
endmodule
